// File: rtl/adxl_emu_pkg.sv
// Shared constants for the ADXL345 SPI responder: register map, reset values,
// FSM states and INT_SOURCE bit positions.
package adxl_emu_pkg;

    localparam logic [5:0] ADDR_DEVID      = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE    = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL  = 6'h2D;
    localparam logic [5:0] ADDR_INT_ENABLE = 6'h2E;
    localparam logic [5:0] ADDR_INT_SOURCE = 6'h30;
    localparam logic [5:0] ADDR_DATAX0     = 6'h32;
    localparam logic [5:0] ADDR_DATAZ1     = 6'h37;

    localparam logic [7:0] BW_RATE_RST     = 8'h0A;

    localparam int POWER_CTL_MEASURE_BIT   = 3;
    localparam int INT_ENABLE_DREADY_BIT   = 7;
    localparam int INT_SOURCE_DREADY_BIT   = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA
    } spi_state_e;

    function automatic logic [7:0] reg_reset_val(input logic [5:0] addr);
        return (addr == ADDR_BW_RATE) ? BW_RATE_RST : 8'h00;
    endfunction

    function automatic logic is_data_reg(input logic [5:0] addr);
        return (addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1);
    endfunction

    function automatic logic is_writable(input logic [5:0] addr);
        return (addr != ADDR_DEVID) && (addr != ADDR_INT_SOURCE) && !is_data_reg(addr);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = (sync_q << 1) | STAGES'(din);
        prev_d = sync_q[STAGES-1];
    end

    // Reset to the pin's idle level so release of reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/adxl345_spi_responder.sv
// Device-side emulation of the ADXL345 on a 3-wire mode-3 SPI link: command
// decode, 64x8 register file, fabric-injected samples and DATA_READY on INT1.
module adxl345_spi_responder
    import adxl_emu_pkg::*;
#(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_sdio_in,
    output logic        spi_sdio_out,
    output logic        spi_sdio_oe,
    output logic        spi_int,
    input  logic        sample_valid,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    output logic        measure_en,
    output logic [3:0]  data_rate
);

    // Pin index: 0 = SCLK, 1 = CS_N, 2 = SDIO.
    localparam logic [2:0] SYNC_RST = 3'b011;

    logic [2:0] pin_raw;
    logic [2:0] sync_lvl;
    logic [2:0] sync_rise;
    logic [2:0] sync_fall;

    assign pin_raw = {spi_sdio_in, spi_cs_n, spi_sclk};

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        spi_sync_edge #(
            .STAGES    (SYNC_STAGES),
            .RESET_VAL (SYNC_RST[gi])
        ) u_sync (
            .clk   (clk_clk),
            .rst_n (reset_reset_n),
            .din   (pin_raw[gi]),
            .dout  (sync_lvl[gi]),
            .rise  (sync_rise[gi]),
            .fall  (sync_fall[gi])
        );
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_active, sdio_s;
    logic sync_unused;

    assign sclk_rise   = sync_rise[0];
    assign sclk_fall   = sync_fall[0];
    assign cs_rise     = sync_rise[1];
    assign cs_fall     = sync_fall[1];
    assign cs_active   = ~sync_lvl[1];
    assign sdio_s      = sync_lvl[2];
    assign sync_unused = sync_lvl[0] ^ sync_rise[2] ^ sync_fall[2];

    spi_state_e  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [5:0]  addr_q, addr_d;
    logic        mb_q, mb_d;
    logic        load_q, load_d;
    logic        data_ready_q, data_ready_d;
    logic        int_q, int_d;
    logic        pend_q, pend_d;
    logic [47:0] pend_data_q, pend_data_d;
    logic [7:0]  regs_q [64];
    logic [7:0]  regs_d [64];

    logic [7:0]  shift_in;
    logic [5:0]  addr_adv;
    logic        wr_en;
    logic        rd_done_z1;
    logic [7:0]  rd_byte;
    logic        sample_take;
    logic        apply;
    logic [47:0] apply_data;

    assign shift_in = {shift_q[6:0], sdio_s};
    assign addr_adv = mb_q ? addr_q + 6'd1 : addr_q;

    always_comb begin
        rd_byte = regs_q[addr_q];
        if (addr_q == ADDR_DEVID) begin
            rd_byte = DEVID;
        end else if (addr_q == ADDR_INT_SOURCE) begin
            rd_byte = 8'h00;
            rd_byte[INT_SOURCE_DREADY_BIT] = data_ready_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        mb_d       = mb_q;
        load_d     = load_q;
        wr_en      = 1'b0;
        rd_done_z1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = 3'd0;
                if (cs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d  = shift_in[5:0];
                        mb_d    = shift_in[6];
                        load_d  = shift_in[7];
                        state_d = shift_in[7] ? ST_RDATA : ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (sclk_rise) begin
                    shift_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        wr_en  = 1'b1;
                        addr_d = addr_adv;
                    end
                end
            end
            ST_RDATA: begin
                // Falling edges present the next bit; the first fall of each
                // byte loads the register addressed at that moment.
                if (sclk_fall) begin
                    if (load_q) begin
                        shift_d = rd_byte;
                        load_d  = 1'b0;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                    end
                end
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        load_d     = 1'b1;
                        addr_d     = addr_adv;
                        rd_done_z1 = (addr_q == ADDR_DATAZ1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            load_d    = 1'b0;
        end
    end

    // Samples arriving mid-transfer are parked so a burst read never sees a
    // torn X/Y/Z set; the newest parked sample wins.
    always_comb begin
        sample_take = sample_valid & measure_en;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        apply       = 1'b0;
        apply_data  = pend_data_q;
        if (sample_take && cs_active) begin
            pend_d      = 1'b1;
            pend_data_d = {sample_z, sample_y, sample_x};
        end else if (sample_take) begin
            apply      = 1'b1;
            apply_data = {sample_z, sample_y, sample_x};
            pend_d     = 1'b0;
        end else if (pend_q && !cs_active) begin
            apply  = 1'b1;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 64; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en && is_writable(addr_q)) begin
            regs_d[addr_q] = shift_in;
        end
        if (apply) begin
            for (int i = 0; i < 6; i++) begin
                regs_d[ADDR_DATAX0 + 6'(i)] = apply_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        data_ready_d = data_ready_q;
        if (rd_done_z1) begin
            data_ready_d = 1'b0;
        end
        if (apply) begin
            data_ready_d = 1'b1;
        end
        int_d = data_ready_q & regs_q[ADDR_INT_ENABLE][INT_ENABLE_DREADY_BIT];
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            addr_q       <= 6'd0;
            mb_q         <= 1'b0;
            load_q       <= 1'b0;
            data_ready_q <= 1'b0;
            int_q        <= 1'b0;
            pend_q       <= 1'b0;
            pend_data_q  <= 48'd0;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= reg_reset_val(6'(i));
            end
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            mb_q         <= mb_d;
            load_q       <= load_d;
            data_ready_q <= data_ready_d;
            int_q        <= int_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign spi_sdio_oe  = (state_q == ST_RDATA);
    assign spi_sdio_out = spi_sdio_oe & shift_q[7];
    assign spi_int      = int_q;
    assign measure_en   = regs_q[ADDR_POWER_CTL][POWER_CTL_MEASURE_BIT];
    assign data_rate    = regs_q[ADDR_BW_RATE][3:0];

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Scoreboard bench for adxl345_spi_responder: directed and random SPI
// transactions against a register-level reference model.
module tb_adxl345_spi_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b1;
    logic        cs_n = 1'b1;
    logic        sdio_in = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic        spi_sdio_out, spi_sdio_oe, spi_int, measure_en;
    logic [3:0]  data_rate;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    adxl345_spi_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .spi_sclk      (sclk),
        .spi_cs_n      (cs_n),
        .spi_sdio_in   (sdio_in),
        .spi_sdio_out  (spi_sdio_out),
        .spi_sdio_oe   (spi_sdio_oe),
        .spi_int       (spi_int),
        .sample_valid  (sample_valid),
        .sample_x      (sample_x),
        .sample_y      (sample_y),
        .sample_z      (sample_z),
        .measure_en    (measure_en),
        .data_rate     (data_rate)
    );

    // Reference model: register contents as the sensor datasheet describes them.
    logic [7:0]  m_regs [64];
    logic        m_dr;
    logic        m_pend;
    logic [15:0] m_px, m_py, m_pz;
    logic        m_cs_low;
    logic [7:0]  exp_q [$];
    logic [7:0]  wq [$];

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
        m_regs[8'h2C] = 8'h0A;
        m_dr = 1'b0;
        m_pend = 1'b0;
        m_cs_low = 1'b0;
    endfunction

    function automatic bit m_writable(int a);
        return a != 0 && a != 8'h30 && !(a >= 8'h32 && a <= 8'h37);
    endfunction

    function automatic logic [7:0] model_read(int a);
        if (a == 0) return 8'hE5;
        if (a == 8'h30) return {m_dr, 7'd0};
        return m_regs[a];
    endfunction

    function automatic void model_apply(logic [15:0] x, logic [15:0] y, logic [15:0] z);
        m_regs[8'h32] = x[7:0]; m_regs[8'h33] = x[15:8];
        m_regs[8'h34] = y[7:0]; m_regs[8'h35] = y[15:8];
        m_regs[8'h36] = z[7:0]; m_regs[8'h37] = z[15:8];
        m_dr = 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: assembles bytes the DUT drives and pops the scoreboard.
    int         mon_bits = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) begin
            mon_bits = 0;
        end else if (spi_sdio_oe) begin
            mon_byte = {mon_byte[6:0], spi_sdio_out};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_byte: got %h expected none (scoreboard empty)", mon_byte);
                end else begin
                    check("rd_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, input logic exp_oe);
        @(negedge clk);
        sclk = 1'b0;
        sdio_in = b;
        idle(HALF - 1);
        check("sdio_oe", 32'(spi_sdio_oe), 32'(exp_oe));
        @(negedge clk);
        sclk = 1'b1;
        idle(HALF - 1);
    endtask

    task automatic spi_byte(input logic [7:0] v, input logic exp_oe);
        for (int i = 7; i >= 0; i--) spi_bit(v[i], exp_oe);
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
        m_cs_low = 1'b1;
        idle(HALF);
    endtask

    task automatic cs_end();
        @(negedge clk);
        cs_n = 1'b1;
        idle(2 * HALF);
        m_cs_low = 1'b0;
        if (m_pend) begin
            model_apply(m_px, m_py, m_pz);
            m_pend = 1'b0;
        end
    endtask

    task automatic spi_write(input logic [5:0] a, input logic mb);
        int cur;
        cur = int'(a);
        cs_begin();
        spi_byte({1'b0, mb, a}, 1'b0);
        foreach (wq[i]) begin
            spi_byte(wq[i], 1'b0);
            if (m_writable(cur)) m_regs[cur] = wq[i];
            if (mb) cur = (cur + 1) % 64;
        end
        cs_end();
        wq.delete();
    endtask

    task automatic spi_read(input logic [5:0] a, input logic mb, input int n);
        int cur;
        cur = int'(a);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_read(cur));
            if (cur == 8'h37) m_dr = 1'b0;
            if (mb) cur = (cur + 1) % 64;
        end
        cs_begin();
        spi_byte({1'b1, mb, a}, 1'b0);
        repeat (n) spi_byte(8'h00, 1'b1);
        cs_end();
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_x = x; sample_y = y; sample_z = z;
        @(negedge clk);
        sample_valid = 1'b0;
        if (m_regs[8'h2D][3]) begin
            if (m_cs_low) begin
                m_pend = 1'b1;
                m_px = x; m_py = y; m_pz = z;
            end else begin
                model_apply(x, y, z);
            end
        end
    endtask

    task automatic check_outputs();
        idle(3);
        check("measure_en", 32'(measure_en), 32'(m_regs[8'h2D][3]));
        check("data_rate", 32'(data_rate), 32'(m_regs[8'h2C][3:0]));
        check("spi_int", 32'(spi_int), 32'(m_dr & m_regs[8'h2E][7]));
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        model_reset();
        idle(5);
        check("rst_sdio_oe", 32'(spi_sdio_oe), 32'd0);
        check("rst_sdio_out", 32'(spi_sdio_out), 32'd0);
        check("rst_spi_int", 32'(spi_int), 32'd0);
        check("rst_measure_en", 32'(measure_en), 32'd0);
        check("rst_data_rate", 32'(data_rate), 32'hA);
        rst_n = 1'b1;
        idle(5);

        // DEVID, write/readback, control outputs
        spi_read(6'h00, 1'b0, 1);
        wq = '{8'h08}; spi_write(6'h2D, 1'b0);
        check_outputs();
        spi_read(6'h2D, 1'b0, 1);
        wq = '{8'h0F}; spi_write(6'h2C, 1'b0);
        check_outputs();

        // Burst data read clears DATA_READY
        wq = '{8'h80}; spi_write(6'h2E, 1'b0);
        strobe(16'h1234, 16'hFFF0, 16'h0100);
        check_outputs();
        spi_read(6'h32, 1'b1, 6);
        check_outputs();

        // Deferred sample: two strobes during CS low, newest applied at CS high
        cs_begin();
        strobe(16'hAAAA, 16'h5555, 16'h7777);
        strobe(16'hBEEF, 16'hCAFE, 16'h0F0F);
        exp_q.push_back(model_read(8'h32));
        spi_byte(8'hB2, 1'b0);
        spi_byte(8'h00, 1'b1);
        cs_end();
        check_outputs();
        spi_read(6'h32, 1'b1, 6);
        check_outputs();

        // Aborted write and read-only DEVID
        cs_begin();
        spi_byte(8'h2C, 1'b0);
        for (int i = 0; i < 4; i++) spi_bit(i[0], 1'b0);
        cs_end();
        spi_read(6'h2C, 1'b0, 1);
        wq = '{8'h12}; spi_write(6'h00, 1'b0);
        spi_read(6'h00, 1'b0, 1);

        // Address wrap and MB=0 hold
        wq = '{8'h55, 8'hAA}; spi_write(6'h3E, 1'b1);
        spi_read(6'h3E, 1'b1, 3);
        spi_read(6'h00, 1'b0, 3);
        check_outputs();

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                int n;
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
                spi_write(6'($urandom), 1'($urandom));
            end else if (kind == 1) begin
                spi_read(6'($urandom), 1'($urandom), int'($urandom_range(1, 4)));
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    wq = '{8'h08}; spi_write(6'h2D, 1'b0);
                end
                strobe(16'($urandom), 16'($urandom), 16'($urandom));
            end
            check_outputs();
        end

        // Reset in the middle of a write
        wq = '{8'h03}; spi_write(6'h2C, 1'b0);
        check_outputs();
        cs_begin();
        spi_byte(8'h2C, 1'b0);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        check("midrst_sdio_oe", 32'(spi_sdio_oe), 32'd0);
        check("midrst_data_rate", 32'(data_rate), 32'hA);
        check("midrst_spi_int", 32'(spi_int), 32'd0);
        cs_n = 1'b1;
        sclk = 1'b1;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(2 * HALF);
        spi_read(6'h2C, 1'b0, 1);
        check_outputs();

        idle(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
